// File: rtl/branch_pkg.sv
// Shared encodings for the branch unit: branch-select codes, 2-bit counter states
// and the saturating counter update used by the BTB.
package branch_pkg;

  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JR   = 2'b10;
  localparam logic [1:0] BS_JMP  = 2'b11;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] r;
    r = ctr;
    if (taken && (ctr != ST)) begin
      r = ctr + 2'd1;
    end else if (!taken && (ctr != SNT)) begin
      r = ctr - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_btb.sv
// Tag-less direct-mapped BTB: valid bits, targets and 2-bit counters with one
// combinational read port and one synchronous update port.
module branch_btb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IdxW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IdxW-1:0] i_rd_idx,
  output logic            o_rd_valid,
  output logic [1:0]      o_rd_ctr,
  output logic [XLEN-1:0] o_rd_tgt,
  input  logic            i_wr_en,
  input  logic [IdxW-1:0] i_wr_idx,
  input  logic            i_wr_taken,
  input  logic [XLEN-1:0] i_wr_tgt
);
  import branch_pkg::*;

  logic [DEPTH-1:0] r_valid;
  logic [1:0]       r_ctr [DEPTH];
  logic [XLEN-1:0]  r_tgt [DEPTH];

  // Read returns pre-update contents; no write-to-read bypass.
  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_ctr   = r_ctr[i_rd_idx];
  assign o_rd_tgt   = r_tgt[i_rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_ctr   <= '{default: WNT};
    end else if (i_wr_en) begin
      if (r_valid[i_wr_idx]) begin
        r_ctr[i_wr_idx] <= ctr_next(r_ctr[i_wr_idx], i_wr_taken);
        if (i_wr_taken) begin
          r_tgt[i_wr_idx] <= i_wr_tgt;
        end
      end else if (i_wr_taken) begin
        r_valid[i_wr_idx] <= 1'b1;
        r_ctr[i_wr_idx]   <= WT;
        r_tgt[i_wr_idx]   <= i_wr_tgt;
      end
    end
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Fetch PC, BTB-based prediction, execute-stage resolution and delayed flush chain.
// Define BRANCH_PRED_STATS_EN to build the saturating branch/mispredict counters.
module branch_pred_unit #(
  parameter int unsigned    XLEN         = 32,
  parameter int unsigned    BTB_DEPTH    = 16,
  parameter int unsigned    FLUSH_STAGES = 2,
  parameter logic [XLEN-1:0] RESET_VEC   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    ex_valid,
  input  logic [1:0]              ex_bs,
  input  logic                    ex_ps,
  input  logic                    ex_zero,
  input  logic [XLEN-1:0]         ex_pc,
  input  logic [XLEN-1:0]         ex_bra,
  input  logic [XLEN-1:0]         ex_raa,
  input  logic                    ex_pred_taken,
  input  logic [XLEN-1:0]         ex_pred_target,
  output logic [XLEN-1:0]         pc,
  output logic                    pred_taken,
  output logic [XLEN-1:0]         pred_target,
  output logic                    flush,
  output logic [FLUSH_STAGES-1:0] flush_dly,
  output logic [31:0]             stat_br,
  output logic [31:0]             stat_mis
);
  import branch_pkg::*;

  localparam int unsigned IdxW = $clog2(BTB_DEPTH);
  localparam logic [XLEN-1:0] PcOne = XLEN'(1);

  logic [XLEN-1:0]         r_pc;
  logic [XLEN-1:0]         w_pc_nxt;
  logic                    r_flush;
  logic [FLUSH_STAGES-1:0] r_flush_dly;
  logic [FLUSH_STAGES-1:0] w_flush_dly_nxt;
  logic                    w_resolve;
  logic                    w_act_taken;
  logic [XLEN-1:0]         w_act_target;
  logic                    w_mis;
  logic                    w_btb_we;
  logic                    w_rd_valid;
  logic [1:0]              w_rd_ctr;
  logic [XLEN-1:0]         w_rd_tgt;

  branch_btb #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH),
    .IdxW  (IdxW)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (r_pc[IdxW-1:0]),
    .o_rd_valid (w_rd_valid),
    .o_rd_ctr   (w_rd_ctr),
    .o_rd_tgt   (w_rd_tgt),
    .i_wr_en    (w_btb_we),
    .i_wr_idx   (ex_pc[IdxW-1:0]),
    .i_wr_taken (w_act_taken),
    .i_wr_tgt   (w_act_target)
  );

  assign pred_taken  = w_rd_valid & w_rd_ctr[1];
  assign pred_target = w_rd_tgt;

  always_comb begin
    w_resolve    = ex_valid && (ex_bs != BS_NONE);
    w_act_taken  = (ex_bs == BS_COND) ? (ex_ps ^ ex_zero) : 1'b1;
    w_act_target = (ex_bs == BS_JR) ? ex_raa : ex_bra;
    w_mis        = w_resolve && ((w_act_taken != ex_pred_taken) ||
                                 (w_act_taken && (ex_pred_target != w_act_target)));
    // Register jumps are never allocated: their targets are data-dependent.
    w_btb_we     = w_resolve && ((ex_bs == BS_COND) || (ex_bs == BS_JMP));
  end

  always_comb begin
    w_pc_nxt = r_pc + PcOne;
    if (w_mis) begin
      w_pc_nxt = w_act_taken ? w_act_target : (ex_pc + PcOne);
    end else if (stall) begin
      w_pc_nxt = r_pc;
    end else if (pred_taken) begin
      w_pc_nxt = pred_target;
    end
  end

  always_comb begin
    w_flush_dly_nxt    = '0;
    w_flush_dly_nxt[0] = r_flush;
    for (int i = 1; i < FLUSH_STAGES; i++) begin
      w_flush_dly_nxt[i] = r_flush_dly[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= RESET_VEC;
      r_flush     <= 1'b1;
      r_flush_dly <= '1;
    end else begin
      r_pc        <= w_pc_nxt;
      r_flush     <= w_mis;
      r_flush_dly <= w_flush_dly_nxt;
    end
  end

  assign pc        = r_pc;
  assign flush     = r_flush;
  assign flush_dly = r_flush_dly;

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mis;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else begin
      if (w_resolve && (r_stat_br != '1)) begin
        r_stat_br <= r_stat_br + 32'd1;
      end
      if (w_mis && (r_stat_mis != '1)) begin
        r_stat_mis <= r_stat_mis + 32'd1;
      end
    end
  end

  assign stat_br  = r_stat_br;
  assign stat_mis = r_stat_mis;
`else
  assign stat_br  = '0;
  assign stat_mis = '0;
`endif

endmodule

// File: doc/branch_pred_unit.md
Name: branch_pred_unit

Overview:
- Parametrised successor to the single-cycle PC-select/flush unit.
- Holds the fetch PC (word-addressed, +1 sequential), predicts taken branches with a direct-mapped BTB and 2-bit counters, and resolves branches from execute.
- Redirects fetch on a mispredict and drives a parametrised chain of delayed flush strobes to the pipeline stages.
- Sits between the fetch stage, the execute-stage branch compare, and the pipeline registers.

Parameters:
- XLEN, 32, PC/target width.
- BTB_DEPTH, 16, BTB entries; power of 2, at least 2; index = pc[log2(BTB_DEPTH)-1:0].
- FLUSH_STAGES, 2, length of the delayed flush chain; at least 1.
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hold the fetch PC.
- ex_valid  in  1  a branch-class instruction is in execute this cycle.
- ex_bs  in  2  branch select: 00 none, 01 conditional, 10 register jump, 11 unconditional.
- ex_ps  in  1  condition polarity; conditional is taken when ex_ps ^ ex_zero.
- ex_zero  in  1  ALU zero flag.
- ex_pc  in  XLEN  PC of the execute instruction.
- ex_bra  in  XLEN  computed branch target.
- ex_raa  in  XLEN  register jump target.
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- ex_pred_target  in  XLEN  predicted target carried down the pipe.
- pc  out  XLEN  current fetch PC.
- pred_taken  out  1  prediction for pc.
- pred_target  out  XLEN  predicted target for pc.
- flush  out  1  registered redirect strobe.
- flush_dly  out  FLUSH_STAGES  flush delayed by 1..FLUSH_STAGES cycles; bit i = flush delayed i+1 cycles.
- stat_br  out  32  resolved-branch count (optional feature).
- stat_mis  out  32  mispredict count (optional feature).

Behaviour:
- Reset (synchronous, rst_n low at posedge clk):
  - pc = RESET_VEC.
  - flush = 1; flush_dly = all ones.
  - All BTB valid bits cleared; counters = 01.
  - stat_br = stat_mis = 0.
  - The reset value wins over any in-flight resolution.
- Prediction (combinational from pc):
  - idx = pc[log2(BTB_DEPTH)-1:0].
  - pred_taken = valid[idx] & ctr[idx][1].
  - pred_target = tgt[idx].
- Resolution, only when ex_valid = 1 and ex_bs != 00:
  - act_taken = 1 for bs 10/11; ex_ps ^ ex_zero for bs 01.
  - act_target = ex_raa for bs 10; ex_bra otherwise.
  - mis = (act_taken != ex_pred_taken) | (act_taken & ex_pred_target != act_target).
  - ex_valid = 0 or bs 00: no update, mis = 0.
- Next-PC priority:
  - mis: act_taken ? act_target : ex_pc + 1.
  - else stall: hold pc.
  - else pred_taken: pred_target.
  - else pc + 1.
  - Addition wraps modulo 2^XLEN.
- A mispredict overrides stall; the redirect is never lost.
- Flush timing:
  - flush <= mis, so it is high exactly one cycle after a mispredict.
  - flush_dly shifts flush in every cycle; stall does not freeze the chain.
- BTB update, one cycle latency, only for bs 01 and 11 (register jumps are never allocated):
  - Entry invalid and act_taken: allocate with valid = 1, tgt = act_target, ctr = 10.
  - Entry invalid and not taken: no allocation.
  - Entry valid: saturating ctr +1 if taken, -1 if not; tgt = act_target when taken.
  - No tag: aliasing is permitted and is corrected by the mispredict path.
- Same-index read and write in one cycle: the read returns the old value (no bypass).

Optional Feature:
- Macro: BRANCH_PRED_STATS_EN.
- Defined: stat_br increments on every resolution; stat_mis increments on every mis. Both saturate at 0xFFFFFFFF.
- Undefined: no counters are built; stat_br and stat_mis are tied to 0.

Decomposition:
- Package branch_pkg holds:
  - BS_NONE / BS_COND / BS_JR / BS_JMP constants.
  - 2-bit counter constants SNT/WNT/WT/ST.
  - The saturating counter-update function.
- Sub-module branch_btb holds the valid/tag-less target/counter arrays: one combinational read port, one synchronous write port.

Test Plan:
- Reset with rst_n=0 for 2 cycles, RESET_VEC=0x100 -> pc=0x100, flush=1, flush_dly=2'b11; after release pc steps 0x101, 0x102.
- Conditional, ex_bs=01, ps=0, zero=1, ex_pc=0x10, ex_bra=0x40, pred not taken -> next pc=0x40; flush=1 one cycle later, flush_dly[0] the cycle after; BTB[0] valid, ctr=10.
- Fetch of pc=0x10 with no stall -> pred_taken=1, pred_target=0x40, next pc=0x40.
- Same branch resolved not taken twice -> ctr 10->01->00; first resolution redirects to 0x11; pred_taken=0 afterwards.
- stall=1 together with a mispredict (bs=10, raa=0x80) -> pc=0x80 despite stall; no BTB allocation.
- With BRANCH_PRED_STATS_EN defined: run 3 resolutions containing 1 mispredict -> stat_br=3, stat_mis=1.
